// File: rtl/posit_cmd_engine.sv
// Command engine between HPS PIO level registers and a pipelined posit core:
// toggle-to-pulse conversion, credit-based issue, pending slot and a result FIFO.
module posit_cmd_engine #(
    parameter int NBITS      = 32,
    parameter int ES         = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OPW        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] io_num1,
    input  logic [NBITS-1:0] io_num2,
    input  logic [7:0]       io_cmd,
    input  logic             io_pop,
    output logic [NBITS-1:0] io_result,
    output logic [15:0]      io_status,
    output logic             core_in_valid,
    output logic [OPW-1:0]   core_op,
    output logic [NBITS-1:0] core_num1,
    output logic [NBITS-1:0] core_num2,
    input  logic             core_out_valid,
    input  logic [NBITS-1:0] core_result,
    input  logic             core_nar
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        OPW < 1 || OPW > 6 || ES < 0 || ES >= NBITS) begin : g_param_check
        $error("posit_cmd_engine: illegal parameter combination");
    end

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
    state_t state_q, state_d;

    logic             armed_q, prev_start_q, prev_clr_q, prev_pop_q;
    logic             core_in_valid_q, core_in_valid_d;
    logic [OPW-1:0]   core_op_q, core_op_d, pend_op_q, pend_op_d;
    logic [NBITS-1:0] core_num1_q, core_num1_d, core_num2_q, core_num2_d;
    logic [NBITS-1:0] pend_num1_q, pend_num1_d, pend_num2_q, pend_num2_d;
    logic [CW-1:0]    inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [NBITS:0]   fifo_mem [FIFO_DEPTH];

    logic start_ev, clr_ev, pop_ev, ok, can_issue;
    logic issue, issue_pend, pend_load, overrun_set;
    logic ret, spurious_set, push, pop, underflow_set;
    logic [CW:0] credit_sum;
    logic [NBITS:0] head;
    logic not_empty, full, busy, head_nar;
    logic unused_cmd;

    assign unused_cmd = ^io_cmd;

    // Edges are suppressed in the arm cycle so levels held across reset never fire.
    assign start_ev = armed_q & (io_cmd[7] ^ prev_start_q);
    assign clr_ev   = armed_q & (io_cmd[6] ^ prev_clr_q);
    assign pop_ev   = armed_q & (io_pop ^ prev_pop_q);

    assign credit_sum    = {1'b0, inflight_q} + {1'b0, count_q};
    assign ok            = credit_sum < (CW+1)'(FIFO_DEPTH);
    assign can_issue     = ok & ~core_in_valid_q;
    assign ret           = core_out_valid & (inflight_q != '0);
    assign spurious_set  = core_out_valid & (inflight_q == '0);
    assign push          = ret;
    assign pop           = pop_ev & (count_q != '0);
    assign underflow_set = pop_ev & (count_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ev && !can_issue) state_d = PENDING;
            PENDING: if (can_issue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        issue_pend  = 1'b0;
        pend_load   = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                issue     = start_ev & can_issue;
                pend_load = start_ev & ~can_issue;
            end
            PENDING: begin
                issue       = can_issue;
                issue_pend  = can_issue;
                overrun_set = start_ev;
            end
            default: ;
        endcase
    end

    always_comb begin
        core_in_valid_d = issue;
        core_op_d       = core_op_q;
        core_num1_d     = core_num1_q;
        core_num2_d     = core_num2_q;
        if (issue && issue_pend) begin
            core_op_d   = pend_op_q;
            core_num1_d = pend_num1_q;
            core_num2_d = pend_num2_q;
        end else if (issue) begin
            core_op_d   = io_cmd[OPW-1:0];
            core_num1_d = io_num1;
            core_num2_d = io_num2;
        end
        pend_op_d   = pend_load ? io_cmd[OPW-1:0] : pend_op_q;
        pend_num1_d = pend_load ? io_num1 : pend_num1_q;
        pend_num2_d = pend_load ? io_num2 : pend_num2_q;
        inflight_d  = inflight_q + CW'(issue) - CW'(ret);
        count_d     = count_q + CW'(push) - CW'(pop);
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        // A set event in the same cycle as a clear wins.
        sticky_d    = (clr_ev ? 3'b000 : sticky_q) | {spurious_set, underflow_set, overrun_set};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q         <= 1'b0;
            prev_start_q    <= 1'b0;
            prev_clr_q      <= 1'b0;
            prev_pop_q      <= 1'b0;
            core_in_valid_q <= 1'b0;
            core_op_q       <= '0;
            core_num1_q     <= '0;
            core_num2_q     <= '0;
            pend_op_q       <= '0;
            pend_num1_q     <= '0;
            pend_num2_q     <= '0;
            inflight_q      <= '0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            sticky_q        <= '0;
        end else begin
            armed_q         <= 1'b1;
            prev_start_q    <= io_cmd[7];
            prev_clr_q      <= io_cmd[6];
            prev_pop_q      <= io_pop;
            core_in_valid_q <= core_in_valid_d;
            core_op_q       <= core_op_d;
            core_num1_q     <= core_num1_d;
            core_num2_q     <= core_num2_d;
            pend_op_q       <= pend_op_d;
            pend_num1_q     <= pend_num1_d;
            pend_num2_q     <= pend_num2_d;
            inflight_q      <= inflight_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            sticky_q        <= sticky_d;
        end
    end

    // Result storage holds data only; validity comes from count_q.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= {core_nar, core_result};
    end

    assign head      = fifo_mem[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign busy      = (state_q == PENDING) | (inflight_q != '0);
    assign head_nar  = not_empty & head[NBITS];

    assign io_result     = not_empty ? head[NBITS-1:0] : '0;
    assign io_status     = {3'b000, 5'(count_q), 1'b0, sticky_q, head_nar, full, ~not_empty, busy};
    assign core_in_valid = core_in_valid_q;
    assign core_op       = core_op_q;
    assign core_num1     = core_num1_q;
    assign core_num2     = core_num2_q;
endmodule
